// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the RAM port arbiter: default RAM geometry and the
// largest supported requester count.
package ram_pkg;

  localparam int RAM_ADDR_W = 3;
  localparam int RAM_DATA_W = 8;
  localparam int N_REQ_DEF  = 2;
  localparam int N_REQ_MAX  = 8;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: packed per-requester commands in,
// one-hot grant/read-valid and shared read data out.
interface ram_port_arbiter_if
  import ram_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  // Handshake: a requester holds req and its command stable until it sees
  // gnt high in the same cycle; the command is taken on that rising edge.
  // rvalid is a one-cycle pulse qualifying the shared rdata.
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Round-robin arbiter: scans req from rr_ptr with wrap, grants the first hit
// one-hot, and moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_next_ptr;
  logic [N-1:0]  w_gnt;
  logic          w_found;
  int            w_j;

  always_comb begin
    w_gnt      = '0;
    w_found    = 1'b0;
    w_next_ptr = r_rr_ptr;
    w_j        = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(r_rr_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && req[w_j]) begin
        w_found    = 1'b1;
        w_gnt[w_j] = 1'b1;
        w_next_ptr = (w_j == N - 1) ? '0 : PW'(w_j + 1);
      end
    end
    // Commands presented while in reset must never be accepted.
    if (rst) w_gnt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rr_ptr <= '0;
    else     r_rr_ptr <= w_next_ptr;
  end

  assign gnt = w_gnt;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between N_REQ requesters: one command
// per cycle onto a registered RAM port, read data routed back two cycles later.
module ram_port_arbiter
  import ram_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  w_gnt;
  logic              w_any;
  logic [IDW-1:0]    w_idx;
  logic              w_cmd_we;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wdata;

  logic              r_s1_rd;
  logic [IDW-1:0]    r_s1_id;
  logic              r_s2_rd;
  logic [IDW-1:0]    r_s2_id;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk (clk),
    .rst (rst),
    .req (bus.req),
    .gnt (w_gnt)
  );

  assign bus.gnt = w_gnt;
  assign w_any   = |w_gnt;

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) w_idx = IDW'(k);
    end
  end

  assign w_cmd_we    = bus.req_we[w_idx];
  assign w_cmd_addr  = bus.req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_cmd_wdata = bus.req_wdata[w_idx*DATA_W +: DATA_W];

  // S1 is the RAM port itself; when idle, address/data hold and the RAM does
  // a throwaway read that no response stage ever tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      r_s1_rd  <= 1'b0;
      r_s1_id  <= '0;
      r_s2_rd  <= 1'b0;
      r_s2_id  <= '0;
    end else begin
      if (w_any) begin
        ram_we   <= w_cmd_we;
        ram_addr <= w_cmd_addr;
        ram_din  <= w_cmd_wdata;
        r_s1_rd  <= ~w_cmd_we;
        r_s1_id  <= w_idx;
      end else begin
        ram_we  <= 1'b0;
        r_s1_rd <= 1'b0;
      end
      r_s2_rd <= r_s1_rd;
      r_s2_id <= r_s1_id;
    end
  end

  always_comb begin
    bus.rvalid          = '0;
    bus.rvalid[r_s2_id] = r_s2_rd;
  end

  assign bus.rdata = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a behavioral 8x8
// single-port RAM attached to its port.
module tb_ram_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] mem [8];

  int checks   = 0;
  int failures = 0;

  ram_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Single-port RAM: no reset, write and read exclusive, registered dout.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rdata;
    logic          chk_port;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] w,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [N-1:0] eg, input logic [N-1:0] erv,
                     input logic [DW-1:0] ed);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.exp_gnt = eg; v.exp_rv = erv; v.exp_rdata = ed;
    v.chk_port = 1'b0; v.exp_we = 1'b0; v.exp_addr = '0; v.exp_din = '0;
    vecs.push_back(v);
  endtask

  task automatic port(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int last;
    last = vecs.size() - 1;
    vecs[last].chk_port = 1'b1;
    vecs[last].exp_we   = w;
    vecs[last].exp_addr = a;
    vecs[last].exp_din  = d;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.req       = v.req;
    bus.req_we    = v.we;
    bus.req_addr  = {v.a1, v.a0};
    bus.req_wdata = {v.d1, v.d0};
  endtask

  initial begin
    // Single read: write A5 to addr 3, then read it back.
    add(0, 2'b01, 2'b01, 3, 0, 8'hA5, 0, 2'b01, 2'b00, 0);
    add(0, 2'b01, 2'b00, 3, 0, 8'hA5, 0, 2'b01, 2'b00, 0); port(1, 3, 8'hA5);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);     port(0, 3, 8'hA5);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 8'hA5); port(0, 3, 8'hA5);
    // Write by 0 followed immediately by read of the same address by 1.
    add(0, 2'b01, 2'b01, 7, 0, 8'h3C, 0, 2'b01, 2'b00, 0);
    add(0, 2'b10, 2'b00, 0, 7, 0, 0, 2'b10, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 8'h3C);
    // Fill addr k with 0x10+k, alternating requesters.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) add(0, 2'b01, 2'b01, AW'(k), 0, DW'(8'h10 + k), 0, 2'b01, 2'b00, 0);
      else            add(0, 2'b10, 2'b10, 0, AW'(k), 0, DW'(8'h10 + k), 2'b10, 2'b00, 0);
      if (k == 1) port(1, 0, 8'h10);
    end
    // Read all eight back-to-back.
    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] rv;
      logic [DW-1:0] rd;
      rv = (k < 2) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      rd = (k < 2) ? 8'h00 : DW'(8'h10 + k - 2);
      if (k % 2 == 0) add(0, 2'b01, 2'b00, AW'(k), 0, 0, 0, 2'b01, rv, rd);
      else            add(0, 2'b10, 2'b00, 0, AW'(k), 0, 0, 2'b10, rv, rd);
    end
    // Both requesting reads: strict alternation starting at 0.
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] g;
      logic [DW-1:0] rd;
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      if (i == 0)      rd = 8'h16;
      else if (i == 1) rd = 8'h17;
      else             rd = (i % 2 == 0) ? 8'h12 : 8'h15;
      add(0, 2'b11, 2'b00, 2, 5, 0, 0, g, g, rd);
    end
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 8'h12);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 8'h15);
    // Read granted, then reset: the read must never return.
    add(0, 2'b10, 2'b00, 0, 2, 0, 0, 2'b10, 2'b00, 0);
    add(1, 2'b11, 2'b00, 4, 2, 0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // Write on the RAM port during reset still lands; pointer returns to 0.
    add(0, 2'b01, 2'b01, 4, 0, 8'h99, 0, 2'b01, 2'b00, 0);
    add(1, 2'b10, 2'b00, 0, 2, 0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b00, 4, 2, 0, 0, 2'b01, 2'b00, 0);
    add(0, 2'b10, 2'b00, 0, 2, 0, 0, 2'b10, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 8'h99);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 8'h12);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // Reset with both requesters asserting.
    rst           = 1'b1;
    bus.req       = 2'b11;
    bus.req_we    = 2'b11;
    bus.req_addr  = {3'd5, 3'd6};
    bus.req_wdata = {8'h55, 8'h66};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'h0);
    chk("reset_ram_we", 32'(ram_we), 32'h0);
    chk("reset_ram_addr", 32'(ram_addr), 32'h0);
    chk("reset_ram_din", 32'(ram_din), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("gnt[row %0d]", i), 32'(bus.gnt), 32'(vecs[i].exp_gnt));
      chk($sformatf("rvalid[row %0d]", i), 32'(bus.rvalid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv != '0)
        chk($sformatf("rdata[row %0d]", i), 32'(bus.rdata), 32'(vecs[i].exp_rdata));
      if (vecs[i].chk_port) begin
        chk($sformatf("ram_we[row %0d]", i), 32'(ram_we), 32'(vecs[i].exp_we));
        chk($sformatf("ram_addr[row %0d]", i), 32'(ram_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("ram_din[row %0d]", i), 32'(ram_din), 32'(vecs[i].exp_din));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one single-port synchronous RAM (8 x 8 by default: `we`, `addr`, `din` in, registered `dout` out; write and read mutually exclusive per cycle) between N_REQ requesters. It accepts at most one command per cycle, registers it onto the RAM port, and routes the RAM's registered read data back to the requester that issued the read, tagged with a valid pulse. It sits between client blocks (DMA, CPU-side bus adapter) and the RAM instance.

## Interface

**Parameters**
- `N_REQ`, default 2: number of requesters, 2..8.
- `ADDR_W`, default 3: RAM address width.
- `DATA_W`, default 8: RAM data width.

**Ports**
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in N_REQ: per-requester command request; held until granted.
- `req_we` in N_REQ: per-requester write (1) / read (0); valid with `req`.
- `req_addr` in N_REQ*ADDR_W: packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- `req_wdata` in N_REQ*DATA_W: packed write data, same packing.
- `gnt` out N_REQ: one-hot, combinational; command of requester i is accepted in the cycle `gnt[i]`=1.
- `rvalid` out N_REQ: one-hot, registered; read data for requester i is present this cycle.
- `rdata` out DATA_W: read data, shared by all requesters, qualified by `rvalid`.
- `ram_we` out 1: registered RAM write enable.
- `ram_addr` out ADDR_W: registered RAM address.
- `ram_din` out DATA_W: registered RAM write data.
- `ram_dout` in DATA_W: RAM registered read data.

## Operation

- Arbitration: each cycle, scan `req` starting at pointer `rr_ptr`, wrapping modulo N_REQ; first set bit wins; `gnt` is one-hot or zero; `gnt` is zero while `rst`=1.
- On a grant to i: `rr_ptr` <= (i+1) mod N_REQ. With no grant, `rr_ptr` holds.
- Command stage (S1): on a grant, register `ram_we`=`req_we[i]`, `ram_addr`=addr_i, `ram_din`=wdata_i, `s1_rd`=~`req_we[i]`, `s1_id`=i. With no grant: `ram_we`<=0, `s1_rd`<=0; `ram_addr`/`ram_din` hold (the idle RAM read is harmless and discarded).
- Response stage (S2): `s2_rd`<=`s1_rd`, `s2_id`<=`s1_id`. `rvalid[s2_id]`=`s2_rd`, driven from registers; `rdata`=`ram_dout` passed through combinationally.
- Writes produce no response. A read issued directly after a write to the same address returns the new data, since the RAM commits the write one cycle before it samples the read.
- Requester contract: hold `req` and the command stable until `gnt` is seen; may deassert or change the command in the cycle after `gnt`.
- No FSM beyond the pipeline: state is `rr_ptr` plus S1/S2 valid, id and type bits.

## Timing

- Grant latency: same cycle as `req`, when no other requester is ahead in round-robin order.
- Throughput: one command per cycle, sustained, mixed reads and writes.
- Read latency: granted in cycle T; RAM port driven in T+1; `rvalid`/`rdata` in T+2.
- Write: granted in T; RAM captures it at the end of T+1.
- Fairness: a continuously requesting requester is granted within N_REQ cycles.
- Reset values: `gnt`=0, `rvalid`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `rr_ptr`=0, S1/S2 valid bits 0. `rdata` follows `ram_dout` and is unqualified.
- Reset mid-operation:
  - A write already on the RAM port in the `rst` cycle still commits, since the RAM has no reset.
  - Reads in S1/S2 are dropped, and `rvalid` is 0 from the cycle after `rst` is sampled.
  - Commands presented during `rst` are not granted.

## Structure

- Shared package `ram_pkg`: `ADDR_W`, `DATA_W` defaults and the `N_REQ` maximum.
- One sub-module, `rr_arbiter`: parameter `N`; inputs `clk`, `rst`, `req[N]`; output one-hot `gnt[N]`; owns `rr_ptr`.
- Top level holds the command mux, the S1/S2 registers and the response demux.
- The bench instantiates `ram_port_arbiter` plus one RAM instance of the type described in the summary.

## Test plan

- Single read: after reset, requester 0 writes 0xA5 to addr 3, then reads addr 3. Expected: `gnt[0]` in the same cycle each time; `rvalid[0]`=1 with `rdata`=0xA5 exactly 2 cycles after the read grant; `rvalid[1]` stays 0.
- Round-robin: `req`=2'b11 held for 6 cycles, both reading. Expected: grants alternate 0,1,0,1,0,1; each `rvalid` pulses 2 cycles after its grant, matching id.
- Write-then-read back-to-back: req0 writes 0x3C to addr 7 in cycle T; req1 reads addr 7 in cycle T+1. Expected: `rvalid[1]` in T+3 with `rdata`=0x3C.
- Fill and check: write addr k = 0x10+k for k=0..7 (including the 7 -> 0 wrap), then read all 8 back-to-back. Expected: `rvalid` on 8 consecutive cycles, data 0x10..0x17 in order.
- Reset mid-flight: assert `rst` in the cycle after a read grant, alongside a pending write already on the RAM port. Expected: no `rvalid` afterwards; `gnt`=0 during reset; the write is visible in a later read; `rr_ptr` back to 0 (requester 0 wins the first contested grant).
